// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard controller
package hazard_pkg;

  // Register address width carried by every stage record
  localparam int INSTR_AW = 5;

  typedef struct packed {
    logic [INSTR_AW-1:0] rs1_addr;
    logic [INSTR_AW-1:0] rs2_addr;
    logic                rs1_used;
    logic                rs2_used;
    logic [INSTR_AW-1:0] rd_addr;
    logic                regWrite;
    logic                memRead;
    logic                memWrite;
  } instr_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2,
    FLUSH  = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forwarding source select for one EX operand
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              rs_used,
  input  instr_t            mem_instr,
  input  instr_t            wb_instr,
  output fwd_sel_t          sel
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired, so a producer writing rd = 0 never forwards
  assign mem_hit = rs_used && mem_instr.regWrite &&
                   (mem_instr.rd_addr[REG_AW-1:0] != '0) &&
                   (mem_instr.rd_addr[REG_AW-1:0] == rs_addr);
  assign wb_hit  = rs_used && wb_instr.regWrite &&
                   (wb_instr.rd_addr[REG_AW-1:0] != '0) &&
                   (wb_instr.rd_addr[REG_AW-1:0] == rs_addr);

  // MEM holds the younger result, so it outranks WB
  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

  logic unused_rec_bits;
  assign unused_rec_bits = ^{mem_instr, wb_instr};

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard FSM: forwarding, load-use stall, memory freeze, branch flush (option HAZARD_PERF_EN)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5,
  parameter int SEL_W    = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  instr_t           de_instr,
  input  instr_t           ex_instr,
  input  instr_t           mem_instr,
  input  instr_t           wb_instr,
  input  logic             br_taken,
  input  logic             dmem_ready,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             stall_fd,
  output logic             flush_de,
  output logic             flush_ex,
  output logic             freeze,
  output logic [1:0]       hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  fwd_sel_t  sel1;
  fwd_sel_t  sel2;
  hz_state_t state;
  hz_state_t state_n;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic br_pend;
  logic br_pend_n;
  logic load_use;
  logic mem_wait;
  logic stall_c;
  logic fde_c;
  logic fex_c;
  logic frz_c;
  logic br_flush;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr   (ex_instr.rs1_addr[REG_AW-1:0]),
    .rs_used   (ex_instr.rs1_used),
    .mem_instr (mem_instr),
    .wb_instr  (wb_instr),
    .sel       (sel1)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr   (ex_instr.rs2_addr[REG_AW-1:0]),
    .rs_used   (ex_instr.rs2_used),
    .mem_instr (mem_instr),
    .wb_instr  (wb_instr),
    .sel       (sel2)
  );

  assign load_use = ex_instr.memRead && (ex_instr.rd_addr[REG_AW-1:0] != '0) &&
                    ((de_instr.rs1_used &&
                      de_instr.rs1_addr[REG_AW-1:0] == ex_instr.rd_addr[REG_AW-1:0]) ||
                     (de_instr.rs2_used &&
                      de_instr.rs2_addr[REG_AW-1:0] == ex_instr.rd_addr[REG_AW-1:0]));

  assign mem_wait = (mem_instr.memRead || mem_instr.memWrite) && !dmem_ready;

  // Per-state control decode; event priority is memory wait, then branch, then load-use
  always_comb begin
    stall_c   = 1'b0;
    fde_c     = 1'b0;
    fex_c     = 1'b0;
    frz_c     = 1'b0;
    br_flush  = 1'b0;
    state_n   = state;
    cnt_n     = cnt;
    br_pend_n = br_pend;
    case (state)
      RUN: begin
        if (mem_wait) begin
          frz_c     = 1'b1;
          br_pend_n = br_taken;
          state_n   = MWAIT;
        end else if (br_taken) begin
          fde_c    = 1'b1;
          fex_c    = 1'b1;
          br_flush = 1'b1;
        end else if (load_use) begin
          stall_c = 1'b1;
          fex_c   = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_n   = 3'(LOAD_LAT - 1);
            state_n = LSTALL;
          end
        end
      end
      LSTALL: begin
        if (mem_wait) begin
          frz_c     = 1'b1;
          br_pend_n = br_taken;
          state_n   = MWAIT;
        end else if (br_taken) begin
          fde_c    = 1'b1;
          fex_c    = 1'b1;
          br_flush = 1'b1;
          cnt_n    = '0;
          state_n  = RUN;
        end else begin
          stall_c = 1'b1;
          fex_c   = 1'b1;
          cnt_n   = cnt - 3'd1;
          if (cnt <= 3'd1) state_n = RUN;
        end
      end
      MWAIT: begin
        if (!dmem_ready) begin
          frz_c = 1'b1;
        end else begin
          br_pend_n = 1'b0;
          if (br_pend)           state_n = FLUSH;
          else if (cnt != '0)    state_n = LSTALL;
          else                   state_n = RUN;
        end
      end
      FLUSH: begin
        // the replayed branch supersedes any stall left over from before the wait
        fde_c    = 1'b1;
        fex_c    = 1'b1;
        br_flush = 1'b1;
        cnt_n    = '0;
        state_n  = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // State, bubble counter and pending-branch flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= RUN;
      cnt     <= '0;
      br_pend <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      br_pend <= br_pend_n;
    end
  end

  // All controls are forced quiet while reset is held
  assign fwd_sel1 = RST_N ? SEL_W'(sel1) : '0;
  assign fwd_sel2 = RST_N ? SEL_W'(sel2) : '0;
  assign stall_fd = RST_N && stall_c;
  assign flush_de = RST_N && fde_c;
  assign flush_ex = RST_N && fex_c;
  assign freeze   = RST_N && frz_c;
  assign hz_state = state;

`ifdef HAZARD_PERF_EN
  // Lost-cycle and branch-flush event counters, free-running with wrap
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_fd || freeze)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_ex && br_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  logic unused_rec_bits;
  assign unused_rec_bits = ^{de_instr, ex_instr};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with LOAD_LAT = 3
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  instr_t     de_instr = '0;
  instr_t     ex_instr = '0;
  instr_t     mem_instr = '0;
  instr_t     wb_instr = '0;
  logic       br_taken = 1'b0;
  logic       dmem_ready = 1'b1;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic       stall_fd;
  logic       flush_de;
  logic       flush_ex;
  logic       freeze;
  logic [1:0] hz_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
`endif

  hazard_ctrl #(.LOAD_LAT(3), .REG_AW(5), .SEL_W(2)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .de_instr   (de_instr),
    .ex_instr   (ex_instr),
    .mem_instr  (mem_instr),
    .wb_instr   (wb_instr),
    .br_taken   (br_taken),
    .dmem_ready (dmem_ready),
    .fwd_sel1   (fwd_sel1),
    .fwd_sel2   (fwd_sel2),
    .stall_fd   (stall_fd),
    .flush_de   (flush_de),
    .flush_ex   (flush_ex),
    .freeze     (freeze),
    .hz_state   (hz_state)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [9:0] v;
    logic       rstn;
    logic       brf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [9:0] act;
  int checks = 0;
  int failures = 0;

  function automatic instr_t mk(input int rs1, input int u1, input int rs2, input int u2,
                                input int rd, input int rw, input int mr, input int mw);
    instr_t i;
    i.rs1_addr = 5'(rs1);
    i.rs2_addr = 5'(rs2);
    i.rs1_used = 1'(u1);
    i.rs2_used = 1'(u2);
    i.rd_addr  = 5'(rd);
    i.regWrite = 1'(rw);
    i.memRead  = 1'(mr);
    i.memWrite = 1'(mw);
    return i;
  endfunction

  // {fwd_sel1, fwd_sel2, stall_fd, flush_de, flush_ex, freeze, hz_state}
  function automatic logic [9:0] ev(input int f1, input int f2, input int st, input int fd,
                                    input int fe, input int fz, input int s);
    return {2'(f1), 2'(f2), 1'(st), 1'(fd), 1'(fe), 1'(fz), 2'(s)};
  endfunction

  task automatic step(input string name, input logic rstn, input instr_t de, input instr_t ex,
                      input instr_t mem, input instr_t wb, input logic br, input logic rdy,
                      input logic [9:0] e, input logic brf);
    exp_t x;
    @(posedge CLK);
    #1;
    RST_N      = rstn;
    de_instr   = de;
    ex_instr   = ex;
    mem_instr  = mem;
    wb_instr   = wb;
    br_taken   = br;
    dmem_ready = rdy;
    x.name = name;
    x.v    = e;
    x.rstn = rstn;
    x.brf  = brf;
    sb.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle and checked mid-cycle
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      act = {fwd_sel1, fwd_sel2, stall_fd, flush_de, flush_ex, freeze, hz_state};
      checks++;
      if (act !== mon_e.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", mon_e.name, act, mon_e.v);
      end
`ifdef HAZARD_PERF_EN
      if (!mon_e.rstn) begin
        m_stall = '0;
        m_flush = '0;
      end
      checks++;
      if (perf_stall_cnt !== m_stall || perf_flush_cnt !== m_flush) begin
        failures++;
        $display("FAIL %s perf: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 mon_e.name, perf_stall_cnt, perf_flush_cnt, m_stall, m_flush);
      end
      if (mon_e.rstn) begin
        if (mon_e.v[5] || mon_e.v[2]) m_stall = m_stall + 32'd1;
        if (mon_e.brf) m_flush = m_flush + 32'd1;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instr_t nop;
    instr_t lw7;
    instr_t mlw4;
    instr_t msw;
    nop  = '0;
    lw7  = mk(0, 0, 0, 0, 7, 1, 1, 0);
    mlw4 = mk(0, 0, 0, 0, 4, 1, 1, 0);
    msw  = mk(0, 0, 0, 0, 0, 0, 0, 1);

    step("rst_init", 1'b0, nop, mk(5,1,0,0,0,0,0,0), mk(0,0,0,0,5,1,0,0), nop, 1'b1, 1'b0,
         ev(0,0,0,0,0,0,0), 1'b0);

    step("fwd_mem_prio", 1'b1, nop, mk(5,1,0,0,0,0,0,0), mk(0,0,0,0,5,1,0,0),
         mk(0,0,0,0,5,1,0,0), 1'b0, 1'b1, ev(1,0,0,0,0,0,0), 1'b0);
    step("fwd_wb", 1'b1, nop, mk(5,1,0,0,0,0,0,0), mk(0,0,0,0,5,0,0,0),
         mk(0,0,0,0,5,1,0,0), 1'b0, 1'b1, ev(2,0,0,0,0,0,0), 1'b0);
    step("fwd_x0", 1'b1, nop, mk(0,1,0,0,0,0,0,0), mk(0,0,0,0,0,1,0,0),
         mk(0,0,0,0,0,1,0,0), 1'b0, 1'b1, ev(0,0,0,0,0,0,0), 1'b0);
    step("fwd_rs2_wb", 1'b1, nop, mk(9,0,9,1,0,0,0,0), mk(0,0,0,0,9,0,0,0),
         mk(0,0,0,0,9,1,0,0), 1'b0, 1'b1, ev(0,2,0,0,0,0,0), 1'b0);
    step("fwd_both_mem", 1'b1, nop, mk(3,1,3,1,0,0,0,0), mk(0,0,0,0,3,1,0,0),
         mk(0,0,0,0,3,1,0,0), 1'b0, 1'b1, ev(1,1,0,0,0,0,0), 1'b0);
    step("fwd_split", 1'b1, nop, mk(3,1,4,1,0,0,0,0), mk(0,0,0,0,4,1,0,0),
         mk(0,0,0,0,3,1,0,0), 1'b0, 1'b1, ev(2,1,0,0,0,0,0), 1'b0);

    step("lu_rd0", 1'b1, mk(0,1,0,0,0,0,0,0), mk(0,0,0,0,0,1,1,0), nop, nop, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,0), 1'b0);
    step("lu_c1", 1'b1, mk(0,0,7,1,0,0,0,0), lw7, nop, nop, 1'b0, 1'b1,
         ev(0,0,1,0,1,0,0), 1'b0);
    step("lu_c2", 1'b1, mk(0,0,7,1,0,0,0,0), nop, lw7, nop, 1'b0, 1'b1,
         ev(0,0,1,0,1,0,1), 1'b0);
    step("lu_c3", 1'b1, mk(0,0,7,1,0,0,0,0), nop, nop, lw7, 1'b0, 1'b1,
         ev(0,0,1,0,1,0,1), 1'b0);
    step("lu_done", 1'b1, mk(0,0,7,1,0,0,0,0), nop, nop, nop, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,0), 1'b0);

    step("mw_c1", 1'b1, nop, mk(4,1,0,0,0,0,0,0), mlw4, nop, 1'b0, 1'b0,
         ev(1,0,0,0,0,1,0), 1'b0);
    for (int k = 2; k <= 4; k++)
      step($sformatf("mw_c%0d", k), 1'b1, nop, mk(4,1,0,0,0,0,0,0), mlw4, nop, 1'b0, 1'b0,
           ev(1,0,0,0,0,1,2), 1'b0);
    step("mw_ready", 1'b1, nop, mk(4,1,0,0,0,0,0,0), mlw4, nop, 1'b0, 1'b1,
         ev(1,0,0,0,0,0,2), 1'b0);
    step("mw_run", 1'b1, nop, nop, nop, nop, 1'b0, 1'b1, ev(0,0,0,0,0,0,0), 1'b0);

    step("br_vs_lu", 1'b1, mk(7,1,0,0,0,0,0,0), lw7, nop, nop, 1'b1, 1'b1,
         ev(0,0,0,1,1,0,0), 1'b1);
    step("br_vs_lu_after", 1'b1, nop, nop, nop, nop, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,0), 1'b0);

    step("bw_entry", 1'b1, nop, nop, msw, nop, 1'b1, 1'b0, ev(0,0,0,0,0,1,0), 1'b0);
    step("bw_wait", 1'b1, nop, nop, msw, nop, 1'b1, 1'b0, ev(0,0,0,0,0,1,2), 1'b0);
    step("bw_ready", 1'b1, nop, nop, msw, nop, 1'b1, 1'b1, ev(0,0,0,0,0,0,2), 1'b0);
    step("bw_flush", 1'b1, nop, nop, nop, nop, 1'b0, 1'b1, ev(0,0,0,1,1,0,3), 1'b1);
    step("bw_run", 1'b1, nop, nop, nop, nop, 1'b0, 1'b1, ev(0,0,0,0,0,0,0), 1'b0);

    step("rs_lu_c1", 1'b1, mk(7,1,0,0,0,0,0,0), lw7, nop, nop, 1'b0, 1'b1,
         ev(0,0,1,0,1,0,0), 1'b0);
    step("rs_lu_c2", 1'b1, mk(7,1,0,0,0,0,0,0), nop, lw7, nop, 1'b0, 1'b1,
         ev(0,0,1,0,1,0,1), 1'b0);
    step("rs_assert", 1'b0, mk(7,1,0,0,0,0,0,0), mk(5,1,0,0,0,0,0,0),
         mk(0,0,0,0,5,1,0,0), nop, 1'b1, 1'b0, ev(0,0,0,0,0,0,0), 1'b0);
    step("rs_release", 1'b1, nop, nop, nop, nop, 1'b0, 1'b1, ev(0,0,0,0,0,0,0), 1'b0);
    step("rs_no_residual", 1'b1, nop, nop, nop, nop, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,0), 1'b0);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage core. It generates forwarding-mux selects for both EX operands and detects load-use hazards, holding decode for a configurable load latency. It also freezes the whole pipeline while data memory is not ready and flushes younger stages on a taken branch. It sits beside the pipeline registers and consumes the decoded `instr_t` record of every stage.

## Interface
Parameters:
- `LOAD_LAT`, default 1: load-use bubble cycles inserted; range 1–4.
- `REG_AW`, default 5: register address width.
- `SEL_W`, default 2: forwarding-select width; fixed at 2.

Ports:
- `CLK`  in  1  core clock; all state on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `de_instr`  in  instr_t  decode-stage record.
- `ex_instr`  in  instr_t  execute-stage record.
- `mem_instr`  in  instr_t  memory-stage record.
- `wb_instr`  in  instr_t  writeback-stage record.
- `br_taken`  in  1  taken branch or jump resolved in EX.
- `dmem_ready`  in  1  data memory has completed the access in MEM.
- `fwd_sel1`  out  SEL_W  rs1 operand select: 0 = RF, 1 = MEM, 2 = WB.
- `fwd_sel2`  out  SEL_W  rs2 operand select, same encoding.
- `stall_fd`  out  1  hold PC and the IF/DE register.
- `flush_de`  out  1  bubble into the IF/DE register.
- `flush_ex`  out  1  bubble into the DE/EX register.
- `freeze`  out  1  hold every pipeline register.
- `hz_state`  out  2  current FSM state, for debug.

`instr_t` fields used: `rs1_addr`, `rs2_addr`, `rs1_used`, `rs2_used`, `rd_addr`, `regWrite`, `memRead`, `memWrite`.

## Operation
- **Forwarding (combinational)**
  - `fwd_selN` = 1 if ex rsN is used, matches `mem.rd_addr`, `mem.regWrite` is set and `mem.rd_addr` != 0.
  - Otherwise 2 for the same test against wb.
  - Otherwise 0.
  - MEM has priority over WB. x0 never forwards.
- **Load-use detect:** `ex.memRead` set, `ex.rd_addr` != 0, and de rs1 or rs2 is used and equals `ex.rd_addr`.
- **Memory wait:** `mem_wait` = (`mem.memRead` or `mem.memWrite`) and not `dmem_ready`.
- **FSM states:** RUN = 0, LSTALL = 1, MWAIT = 2, FLUSH = 3.
- **Event priority in RUN:** `mem_wait`, then `br_taken`, then load-use.
- **RUN**
  - `mem_wait`: assert `freeze`, go to MWAIT.
  - Else `br_taken`: assert `flush_de` and `flush_ex`, stay in RUN.
  - Else load-use: assert `stall_fd` and `flush_ex`. If LOAD_LAT > 1, load `cnt` = LOAD_LAT-1 and go to LSTALL.
- **LSTALL**
  - Assert `stall_fd` and `flush_ex`, decrement `cnt`, return to RUN when `cnt` reaches 1.
  - `mem_wait` overrides: go to MWAIT and keep `cnt`.
  - `br_taken` aborts the stall: flush as in RUN, go to RUN.
- **MWAIT**
  - `freeze` is held high. All other outputs are 0.
  - When `dmem_ready` rises, go to FLUSH if `br_taken` was sampled high on MWAIT entry (latched `br_pend`), else LSTALL if `cnt` > 0, else RUN.
- **FLUSH:** assert `flush_de` and `flush_ex` for one cycle, go to RUN.
- Forwarding selects remain valid in every state.

## Timing
- Forwarding, stall, flush and freeze are combinational from the current inputs and state; zero-cycle latency.
- State, `cnt` and `br_pend` update on the `CLK` rising edge.
- Load-use bubble count equals LOAD_LAT exactly when no other event intervenes.
- `freeze` deasserts in the same cycle `dmem_ready` = 1 is seen.
- **Reset:** while `RST_N` = 0, state = RUN, `cnt` = 0 and `br_pend` = 0. All outputs are forced to 0, including `fwd_sel1`/`fwd_sel2`, and `hz_state` = 0.
- **Reset mid-stall or mid-wait:** the block returns to RUN asynchronously. There is no residual stall after release.
- **Simultaneous events:**
  - Load-use together with `br_taken`: flush wins and no stall.
  - `mem_wait` together with either: freeze wins; a pending branch is replayed via FLUSH.

## Configuration
- Macro `HAZARD_PERF_EN`.
- **Defined:** add outputs `perf_stall_cnt` (32) and `perf_flush_cnt` (32), both 0 at reset.
  - `perf_stall_cnt` increments on each cycle with `stall_fd` or `freeze` high.
  - `perf_flush_cnt` increments on each cycle with `flush_ex` caused by a branch.
  - Both wrap at 2^32.
- **Undefined:** the ports and counters are absent. Functional behaviour is identical.

## Structure
- `hazard_pkg` holds:
  - `instr_t`;
  - `fwd_sel_t` enum: FWD_RF, FWD_MEM, FWD_WB;
  - `hz_state_t` enum: RUN, LSTALL, MWAIT, FLUSH.
- Sub-module `hazard_fwd_sel` is instantiated twice, once per source operand. It takes rs address, rs used, and the mem and wb records, and returns `fwd_sel_t`.
- FSM, counter and perf counters live in `hazard_ctrl`.

## Test plan
- **Forwarding priority:** ex rs1 = 5 used; mem rd = 5 regWrite; wb rd = 5 regWrite -> `fwd_sel1` = 1. Clear mem regWrite -> 2. Set rd = 0 on both -> 0.
- **Load-use, LOAD_LAT = 3:** ex lw rd = 7; de rs2 = 7 used -> `stall_fd` = `flush_ex` = 1 for exactly 3 cycles, `hz_state` 0→1→1→0.
- **Memory wait:** mem lw with `dmem_ready` = 0 for 4 cycles -> `freeze` = 1 for 4 cycles and `hz_state` = 2. `freeze` = 0 the cycle `dmem_ready` = 1.
- **Branch versus load-use:** `br_taken` = 1 with a load-use present -> `flush_de` = `flush_ex` = 1, `stall_fd` = 0.
- **Branch during wait:** `br_taken` = 1 and `mem_wait` in the same cycle -> freeze until ready, then one FLUSH cycle, then RUN.
- **Reset mid-LSTALL:** drop `RST_N` -> all outputs 0 immediately. After release, `hz_state` = 0; with `HAZARD_PERF_EN` defined, both counters read 0.
